// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter and wait-state sequencer for the external memory bus
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W = 4
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req0,
  input  logic        wr_rd0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        ack0,
  output logic        gnt0,
  input  logic        req1,
  input  logic        wr_rd1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        ack1,
  output logic        gnt1,
  output logic        CS,
  output logic        WR_RD,
  output logic [31:0] ADDR,
  output logic [31:0] Data_BUS_WRITE,
  input  logic [31:0] Data_BUS_READ,
  output logic        busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             owner;
  logic             any_req;
  logic             pick1;
  logic             grant;
  logic             finish;
  // Master 1 wins when alone, or on a tie when master 0 had the previous grant
  always_comb begin
    any_req = req0 | req1;
    pick1   = req1 & (~req0 | ~last_grant);
    grant   = (state == IDLE) & any_req;
    finish  = (state == ACCESS) & (cnt == '0);
  end
  // Sequencer: grant, count wait states, pulse ack, then one DONE cycle back to IDLE
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      CS         <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
    end else if (grant) begin
      state      <= ACCESS;
      cnt        <= CNT_W'(WAIT_STATES);
      owner      <= pick1;
      last_grant <= pick1;
      CS         <= 1'b1;
      gnt0       <= ~pick1;
      gnt1       <= pick1;
      busy       <= 1'b1;
    end else if (finish) begin
      state <= DONE;
      CS    <= 1'b0;
      ack0  <= ~owner;
      ack1  <= owner;
    end else if (state == ACCESS) begin
      cnt <= cnt - 1'b1;
    end else if (state != IDLE) begin
      state <= IDLE;
      CS    <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
    end
  end
  // Bus latch on grant; read data captured for the owner in the final access cycle
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      WR_RD          <= 1'b0;
      ADDR           <= '0;
      Data_BUS_WRITE <= '0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else if (grant) begin
      WR_RD          <= pick1 ? wr_rd1 : wr_rd0;
      ADDR           <= pick1 ? addr1 : addr0;
      Data_BUS_WRITE <= pick1 ? wdata1 : wdata0;
    end else if (finish && !WR_RD) begin
      rdata0 <= owner ? rdata0 : Data_BUS_READ;
      rdata1 <= owner ? Data_BUS_READ : rdata1;
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the CPU's single external memory bus (CS, WR_RD, ADDR, Data_BUS_WRITE, Data_BUS_READ).
- Master 0 is the CPU load/store port. Master 1 is a secondary requester (DMA / I/O engine).
- Grants the bus round-robin, latches the winning transaction, holds CS for a fixed number of memory wait states, captures read data and returns a one-cycle ack to the winner.
- Sits between the cpu core and memory at the top level.

Parameters:
- WAIT_STATES, 2, extra cycles CS is held beyond the first access cycle; legal 0..15.
- CNT_W, 4, width of the wait-state counter; must hold WAIT_STATES.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0  in  1  master 0 request; held high until ack0.
- wr_rd0  in  1  master 0 direction: 1 = write, 0 = read.
- addr0  in  32  master 0 address.
- wdata0  in  32  master 0 write data.
- rdata0  out  32  master 0 read data; valid when ack0=1 on a read.
- ack0  out  1  master 0 completion pulse, one cycle.
- gnt0  out  1  master 0 currently owns the bus.
- req1, wr_rd1, addr1, wdata1, rdata1, ack1, gnt1: same as master 0, for master 1.
- CS  out  1  memory chip select.
- WR_RD  out  1  memory direction: 1 = write, 0 = read.
- ADDR  out  32  memory address.
- Data_BUS_WRITE  out  32  memory write data.
- Data_BUS_READ  in  32  memory read data; sampled in the last ACCESS cycle.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. CS, WR_RD, ack0/1, gnt0/1, busy = 0. ADDR, Data_BUS_WRITE, rdata0/1 = 0. last_grant=1, so master 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that master.
  - Both high: grant the master that is not last_grant.
  - On grant: latch the winner's wr_rd/addr/wdata onto WR_RD/ADDR/Data_BUS_WRITE. Set CS=1, gnt=1 for the winner, last_grant=winner, counter=WAIT_STATES. Go to ACCESS.
- ACCESS: CS stays high and the bus signals stay stable (latched, independent of later master input changes).
  - counter != 0: decrement.
  - counter == 0:
    - On a read, capture Data_BUS_READ into the winner's rdata.
    - Set CS=0 and pulse the winner's ack=1.
    - Go to DONE.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
- DONE: one cycle. ack=1, gnt still held, CS=0. Next state is IDLE with ack=0 and gnt=0.
  - The arbiter does not sample requests in DONE. The master deasserts req on the edge where it sees ack.
- Latency: req sampled in IDLE at cycle 0 -> CS high in cycles 1..WAIT_STATES+1 -> ack in cycle WAIT_STATES+2 -> IDLE in cycle WAIT_STATES+3.
- The losing requester's req is ignored until the arbiter returns to IDLE. A request left high after ack counts as a new transaction.
- Writes leave rdata unchanged. rdataN holds its value until the next read completes for master N.
- ADDR, WR_RD and Data_BUS_WRITE keep their last values in IDLE; only CS qualifies them.
- Only one of gnt0/gnt1 may be high at any time, and only one of ack0/ack1.
- Reset mid-transaction: CS drops immediately, no ack is issued, and the aborted transaction is lost. Masters must re-request.
- The counter never underflows. WAIT_STATES=0 gives a single ACCESS cycle.

Test Plan:
- Reset, then single read: rst low 5 cycles, then high. Issue req0=1, wr_rd0=0, addr0=0x00000010, with memory returning 0xDEADBEEF. Required: CS high exactly 3 cycles with ADDR=0x10, WR_RD=0. ack0 pulses in cycle 4 with rdata0=0xDEADBEEF. gnt1 and ack1 never assert.
- Single write by master 1: req1, wr_rd1=1, addr1=0x40, wdata1=0x12345678. Required: CS for 3 cycles with WR_RD=1 and Data_BUS_WRITE=0x12345678. ack1 pulses once. rdata1 unchanged.
- Simultaneous requests held continuously for 4 transactions. Required grant order 0,1,0,1, with exactly one IDLE cycle between transactions and gnt0/gnt1 never both high.
- Master changes addr0 mid-ACCESS from 0x10 to 0x20. Required: ADDR stays 0x10 until CS falls.
- Reset asserted in the 2nd ACCESS cycle. Required: CS, gnt0 and busy go 0 asynchronously, and ack0 never pulses. After release, the first tie grants master 0.
- WAIT_STATES=0 build, read 0xA5A5A5A5. Required: CS high 1 cycle, ack in cycle 2, rdata=0xA5A5A5A5.
